// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - tag-pipeline data-hazard scoreboard with forwarding and stall counter
// Optional feature macro: HAZARD_FWD_EN (operand forwarding; undefined = stall until writeback retires)
module hazard_scoreboard #(
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int LW      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_wen,
  input  logic [AW-1:0]         id_waddr,
  input  logic [LW-1:0]         id_rdy_stage,
  input  logic [NUM_SRC-1:0]    src_used,
  input  logic [NUM_SRC*AW-1:0] src_addr,
  input  logic [DEPTH*DW-1:0]   stage_wdata,
  input  logic                  hold,
  input  logic                  flush,
  output logic [NUM_SRC-1:0]    fwd_hit,
  output logic [NUM_SRC*DW-1:0] fwd_data,
  output logic                  stallreq_for_id,
  output logic [31:0]           stall_cnt
);

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // One tag per tracked stage: valid, destination register, first stage with valid result
  logic [DEPTH-1:0]         v_q, v_d;
  logic [DEPTH-1:0][AW-1:0] waddr_q, waddr_d;
  logic [DEPTH-1:0][LW-1:0] rdy_q, rdy_d;
  logic [31:0]              stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0]       blocking;
  logic                     issue;

  // Per-source lookup: youngest matching tag decides between forwarding and blocking
  always_comb begin
    logic found;
    logic fwd_ok;
    fwd_hit  = '0;
    fwd_data = '0;
    blocking = '0;
    found    = 1'b0;
    fwd_ok   = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      found = 1'b0;
      if (src_used[s] && (src_addr[s*AW +: AW] != '0)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && v_q[i] && (waddr_q[i] == src_addr[s*AW +: AW])) begin
            found  = 1'b1;
            // Without forwarding every in-flight producer blocks until it retires
            fwd_ok = FWD_EN && (int'(rdy_q[i]) <= i);
            if (fwd_ok) begin
              fwd_hit[s]             = 1'b1;
              fwd_data[s*DW +: DW]   = stage_wdata[i*DW +: DW];
            end else begin
              blocking[s] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign stallreq_for_id = id_valid && (|blocking);

  // Only a real register write from a non-stalled, non-flushed ID instruction creates a tag
  assign issue = id_valid && !stallreq_for_id && !flush && id_wen && (id_waddr != '0);

  // Tag pipeline advance; flush clears entry 0 even while the rest is frozen by hold
  always_comb begin
    v_d     = v_q;
    waddr_d = waddr_q;
    rdy_d   = rdy_q;
    if (!hold) begin
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i]     = v_q[i-1];
        waddr_d[i] = waddr_q[i-1];
        rdy_d[i]   = rdy_q[i-1];
      end
      v_d[0]     = issue;
      waddr_d[0] = id_waddr;
      rdy_d[0]   = id_rdy_stage;
    end else if (flush) begin
      v_d[0] = 1'b0;
    end
  end

  // Saturating hazard-stall counter
  assign stall_cnt_d = (stallreq_for_id && (stall_cnt_q != 32'hFFFF_FFFF)) ?
                       stall_cnt_q + 32'd1 : stall_cnt_q;

  assign stall_cnt = stall_cnt_q;

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q         <= '0;
      waddr_q     <= '0;
      rdy_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      waddr_q     <= waddr_d;
      rdy_q       <= rdy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_wen;
  logic [4:0]  id_waddr;
  logic [1:0]  id_rdy_stage;
  logic [1:0]  src_used;
  logic [9:0]  src_addr;
  logic [95:0] stage_wdata;
  logic        hold;
  logic        flush;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;
  logic        stallreq_for_id;
  logic [31:0] stall_cnt;

  int checks;
  int failures;

  hazard_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_wen          (id_wen),
    .id_waddr        (id_waddr),
    .id_rdy_stage    (id_rdy_stage),
    .src_used        (src_used),
    .src_addr        (src_addr),
    .stage_wdata     (stage_wdata),
    .hold            (hold),
    .flush           (flush),
    .fwd_hit         (fwd_hit),
    .fwd_data        (fwd_data),
    .stallreq_for_id (stallreq_for_id),
    .stall_cnt       (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic wen, input logic [4:0] wa, input logic [1:0] rdy);
    id_valid     = v;
    id_wen       = wen;
    id_waddr     = wa;
    id_rdy_stage = rdy;
  endtask

  task automatic set_src(input logic [1:0] used, input logic [4:0] a0, input logic [4:0] a1);
    src_used = used;
    src_addr = {a1, a0};
  endtask

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    stage_wdata = {d2, d1, d0};
  endtask

  task automatic do_reset();
    drive_id(1'b0, 1'b0, 5'd0, 2'd0);
    set_src(2'b00, 5'd0, 5'd0);
    hold  = 1'b0;
    flush = 1'b0;
    rst   = 1'b0;
    #1;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with a live producer/consumer on the inputs
    rst   = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    drive_id(1'b1, 1'b1, 5'd3, 2'd0);
    set_src(2'b11, 5'd3, 5'd3);
    set_data(32'h0000_1234, 32'h0000_5678, 32'h0000_9ABC);
    #2;
    check("reset_stall", {31'd0, stallreq_for_id}, 32'd0);
    check("reset_hit", {30'd0, fwd_hit}, 32'd0);
    check("reset_data0", fwd_data[31:0], 32'd0);
    check("reset_cnt", stall_cnt, 32'd0);
    tick();
    check("reset_edge_stall", {31'd0, stallreq_for_id}, 32'd0);
    rst = 1'b1;

    // ALU producer then back-to-back dependent
    set_src(2'b00, 5'd0, 5'd0);
    drive_id(1'b1, 1'b1, 5'd3, 2'd0);
    #1;
    check("alu_producer_stall", {31'd0, stallreq_for_id}, 32'd0);
    tick();
    drive_id(1'b1, 1'b1, 5'd4, 2'd0);
    set_src(2'b11, 5'd3, 5'd3);
    #1;
`ifdef HAZARD_FWD_EN
    check("alu_fwd_hit", {30'd0, fwd_hit}, 32'd3);
    check("alu_fwd_data0", fwd_data[31:0], 32'h0000_1234);
    check("alu_fwd_data1", fwd_data[63:32], 32'h0000_1234);
    check("alu_fwd_stall", {31'd0, stallreq_for_id}, 32'd0);
    tick();
    check("alu_fwd_cnt", stall_cnt, 32'd0);
`else
    check("alu_nofwd_stall0", {31'd0, stallreq_for_id}, 32'd1);
    check("alu_nofwd_hit", {30'd0, fwd_hit}, 32'd0);
    check("alu_nofwd_data", fwd_data[31:0], 32'd0);
    tick();
    check("alu_nofwd_stall1", {31'd0, stallreq_for_id}, 32'd1);
    tick();
    check("alu_nofwd_stall2", {31'd0, stallreq_for_id}, 32'd1);
    tick();
    check("alu_nofwd_release", {31'd0, stallreq_for_id}, 32'd0);
    check("alu_nofwd_cnt", stall_cnt, 32'd3);
`endif

`ifdef HAZARD_FWD_EN
    // Load-use: one stall, then forward from stage 1
    do_reset();
    drive_id(1'b1, 1'b1, 5'd5, 2'd1);
    tick();
    drive_id(1'b1, 1'b1, 5'd6, 2'd0);
    set_src(2'b01, 5'd5, 5'd0);
    #1;
    check("ld_use_stall", {31'd0, stallreq_for_id}, 32'd1);
    check("ld_use_nohit", {30'd0, fwd_hit}, 32'd0);
    tick();
    check("ld_use_release", {31'd0, stallreq_for_id}, 32'd0);
    check("ld_use_hit", {30'd0, fwd_hit}, 32'd1);
    check("ld_use_data", fwd_data[31:0], 32'h0000_5678);
    check("ld_use_cnt", stall_cnt, 32'd1);
`endif

    // $0 destination, non-writing instruction, unused source, id_valid low
    do_reset();
    drive_id(1'b1, 1'b1, 5'd0, 2'd0);
    tick();
    drive_id(1'b1, 1'b0, 5'd8, 2'd0);
    tick();
    drive_id(1'b1, 1'b0, 5'd0, 2'd0);
    set_src(2'b11, 5'd0, 5'd8);
    #1;
    check("zero_nowen_stall", {31'd0, stallreq_for_id}, 32'd0);
    check("zero_nowen_hit", {30'd0, fwd_hit}, 32'd0);
    tick();
    drive_id(1'b1, 1'b1, 5'd12, 2'd0);
    set_src(2'b00, 5'd0, 5'd0);
    tick();
    drive_id(1'b1, 1'b0, 5'd0, 2'd0);
    set_src(2'b00, 5'd12, 5'd12);
    #1;
    check("unused_src_stall", {31'd0, stallreq_for_id}, 32'd0);
    check("unused_src_hit", {30'd0, fwd_hit}, 32'd0);
    set_src(2'b10, 5'd12, 5'd12);
    #1;
    check("used_src1_hit", {30'd0, fwd_hit}, FWD ? 32'd2 : 32'd0);
    check("used_src1_data", fwd_data[63:32], FWD ? 32'h0000_1234 : 32'd0);
    check("used_src1_stall", {31'd0, stallreq_for_id}, FWD ? 32'd0 : 32'd1);
    id_valid = 1'b0;
    #1;
    check("no_id_valid_stall", {31'd0, stallreq_for_id}, 32'd0);

    // Youngest match wins: $7 in stages 0 and 2
    do_reset();
    drive_id(1'b1, 1'b1, 5'd7, 2'd0);
    tick();
    drive_id(1'b1, 1'b1, 5'd11, 2'd0);
    tick();
    drive_id(1'b1, 1'b1, 5'd7, 2'd0);
    tick();
    set_data(32'h0000_BBBB, 32'h0000_5678, 32'h0000_AAAA);
    drive_id(1'b1, 1'b0, 5'd0, 2'd0);
    set_src(2'b01, 5'd7, 5'd0);
    #1;
    check("youngest_data", fwd_data[31:0], FWD ? 32'h0000_BBBB : 32'd0);
    check("youngest_hit", {30'd0, fwd_hit}, FWD ? 32'd1 : 32'd0);
    check("youngest_stall", {31'd0, stallreq_for_id}, FWD ? 32'd0 : 32'd1);

    // Load in stage 0 frozen by hold for three cycles
    do_reset();
    set_data(32'h0000_1234, 32'h0000_5678, 32'h0000_9ABC);
    drive_id(1'b1, 1'b1, 5'd5, 2'd1);
    tick();
    drive_id(1'b1, 1'b1, 5'd6, 2'd0);
    set_src(2'b01, 5'd5, 5'd0);
    hold = 1'b1;
    #1;
    check("hold_c0", {31'd0, stallreq_for_id}, 32'd1);
    tick();
    check("hold_c1", {31'd0, stallreq_for_id}, 32'd1);
    tick();
    check("hold_c2", {31'd0, stallreq_for_id}, 32'd1);
    tick();
    hold = 1'b0;
    #1;
    check("hold_c3", {31'd0, stallreq_for_id}, 32'd1);
    tick();
`ifdef HAZARD_FWD_EN
    check("hold_release", {31'd0, stallreq_for_id}, 32'd0);
    check("hold_fwd_hit", {30'd0, fwd_hit}, 32'd1);
    check("hold_fwd_data", fwd_data[31:0], 32'h0000_5678);
    check("hold_cnt", stall_cnt, 32'd4);
`else
    check("hold_c4", {31'd0, stallreq_for_id}, 32'd1);
    tick();
    check("hold_c5", {31'd0, stallreq_for_id}, 32'd1);
    tick();
    check("hold_release", {31'd0, stallreq_for_id}, 32'd0);
    check("hold_cnt", stall_cnt, 32'd6);
`endif

    // Flush together with hold: entry 0 cleared, entry 1 frozen
    do_reset();
    drive_id(1'b1, 1'b1, 5'd10, 2'd0);
    tick();
    drive_id(1'b1, 1'b1, 5'd5, 2'd1);
    tick();
    drive_id(1'b1, 1'b1, 5'd6, 2'd0);
    set_src(2'b11, 5'd5, 5'd10);
    hold  = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_pre_stall", {31'd0, stallreq_for_id}, 32'd1);
    tick();
    hold  = 1'b0;
    flush = 1'b0;
    set_src(2'b01, 5'd5, 5'd10);
    #1;
    check("flush_clears_e0", {31'd0, stallreq_for_id}, 32'd0);
    set_src(2'b10, 5'd5, 5'd10);
    #1;
`ifdef HAZARD_FWD_EN
    check("flush_hold_e1_hit", {30'd0, fwd_hit}, 32'd2);
    check("flush_hold_e1_data", fwd_data[63:32], 32'h0000_5678);
`else
    check("flush_hold_e1_stall1", {31'd0, stallreq_for_id}, 32'd1);
    tick();
    check("flush_hold_e1_stall2", {31'd0, stallreq_for_id}, 32'd1);
    tick();
    check("flush_hold_e1_drain", {31'd0, stallreq_for_id}, 32'd0);
`endif

    // Counter saturation during an indefinitely held stall, then reset mid-stall
    do_reset();
    drive_id(1'b1, 1'b1, 5'd5, 2'd1);
    tick();
    drive_id(1'b1, 1'b1, 5'd6, 2'd0);
    set_src(2'b01, 5'd5, 5'd0);
    hold = 1'b1;
    #1;
    force dut.stall_cnt_d = 32'hFFFF_FFFE;
    tick();
    release dut.stall_cnt_d;
    #1;
    check("sat_preload", stall_cnt, 32'hFFFF_FFFE);
    tick();
    check("sat_reach", stall_cnt, 32'hFFFF_FFFF);
    tick();
    check("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    check("sat_stall_still", {31'd0, stallreq_for_id}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, stallreq_for_id}, 32'd0);
    check("rst_mid_cnt", stall_cnt, 32'd0);
    tick();
    rst = 1'b1;
    hold = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard unit for the pipelined MIPS core, sitting beside ID. It replaces the fixed per-stage `ex_to_id` / `mem_to_id` / `wb_to_id` forwarding buses with a tag pipeline of configurable depth. It tracks each in-flight register write and the stage in which its result becomes valid. From that it drives per-source forwarding data, the `stallreq_for_id` stall request to CTRL, and a hazard-stall performance counter.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- DEPTH, 3: number of tracked stages after ID. Stage 0 is EX and stage DEPTH-1 is WB.
- NUM_SRC, 2: number of source operands looked up per cycle.
- AW, 5: register address width.
- DW, 32: data width.
- LW, 2: width of the ready-stage field. It must satisfy 2^LW ≥ DEPTH.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a valid instruction.
- id_wen  input  1  the ID instruction writes a register.
- id_waddr  input  AW  destination register.
- id_rdy_stage  input  LW  first stage index whose result is valid: 0 for ALU, 1 for load, and higher for later-completing ops.
- src_used  input  NUM_SRC  per-source valid.
- src_addr  input  NUM_SRC*AW  source register addresses; source s occupies bits [s*AW +: AW].
- stage_wdata  input  DEPTH*DW  result data currently in stage i; stage i occupies bits [i*DW +: DW].
- hold  input  1  freeze the whole tracked pipeline (EX stall, e.g. divider busy).
- flush  input  1  kill the ID instruction and entry 0.
- fwd_hit  output  NUM_SRC  source s takes `fwd_data` instead of the regfile value.
- fwd_data  output  NUM_SRC*DW  forwarded operands.
- stallreq_for_id  output  1  hazard stall request to CTRL.
- stall_cnt  output  32  saturating count of hazard-stall cycles.

## Operation
- Each entry i holds `v`, `waddr` and `rdy`.
- An entry is created only when `id_wen=1` and `id_waddr≠0`. Register $0 never creates a hazard.
- Lookup for source s is combinational. It is skipped when `src_used[s]=0` or `src_addr[s]=0`.
- Lookup scans stages i = 0..DEPTH-1 and selects the youngest (lowest i) valid entry whose `waddr` equals `src_addr[s]`. Older matches are ignored.
- With a match at stage i and `i ≥ rdy[i]`:
  - `fwd_hit[s]=1`;
  - `fwd_data[s]=stage_wdata[i]`.
- With a match at stage i and `i < rdy[i]`: the source is blocking.
- When no match is found: `fwd_hit[s]=0` and `fwd_data[s]=0`.
- `stallreq_for_id` = `id_valid` AND (any source blocking).
- Pipeline advance at posedge clk:
  - If `hold=1`, all entries keep their value.
  - Otherwise, for i ≥ 1, entry[i] takes entry[i-1]. The entry leaving stage DEPTH-1 is dropped.
  - Otherwise, entry[0] takes the ID instruction's tag when `id_valid=1`, `stallreq_for_id=0`, `flush=0` and the entry-creation rule holds; in all other cases it takes a bubble (v=0).
- `flush=1` with `hold=1`: entry 0 is cleared and all other entries hold. Flush wins over hold for entry 0.
- `stall_cnt` increments on every posedge where `stallreq_for_id=1`. It saturates at 0xFFFF_FFFF and never wraps.

## Timing
- Reset: all entries have v=0 and `stall_cnt=0`. Consequently `fwd_hit=0`, `fwd_data=0` and `stallreq_for_id=0`.
- Reset takes effect asynchronously on assertion; release is sampled at clk.
- Lookup has zero latency: outputs depend on the current entries and inputs in the same cycle.
- Tag state changes only at posedge.
- ALU to dependent op back-to-back: producer at stage 0 with rdy=0 gives a forward in the next cycle with no stall.
- Load to dependent op: exactly one stall cycle. The match is at stage 0 with rdy=1, and the next cycle forwards from stage 1.
- An op with rdy=r stalls a back-to-back dependent for r cycles. This excludes extra `hold` cycles, which freeze the count.
- `hold` asserted during a blocking stall: `stallreq_for_id` stays high and `stall_cnt` keeps counting.
- `rst` asserted mid-stall: all state is cleared immediately.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding is enabled as described above.
- `HAZARD_FWD_EN` undefined:
  - `fwd_hit` and `fwd_data` are tied to 0;
  - any valid match blocks, regardless of `rdy`;
  - a dependent waits until its producer has left stage DEPTH-1, relying on regfile write-through.
  - Back-to-back ALU dependency, DEPTH=3: 3 stall cycles.

## Test plan
- ALU forwarding: `addu $3`, then `addu $4,$3,$3` back-to-back, with stage_wdata[0]=0x1234 → `fwd_hit=2'b11`, both `fwd_data=0x1234`, no stall, `stall_cnt=0`.
- Load-use: `lw $5` (rdy=1), then `or $6,$5,$0` → `stallreq_for_id=1` for 1 cycle; next cycle `fwd_hit[0]=1` with stage_wdata[1]; `stall_cnt=1`.
- Youngest wins: writes to $7 in stages 2 and 0 (values 0xAAAA / 0xBBBB) → `fwd_data=0xBBBB`.
- $0 and unused: `id_waddr=0` then `src_addr=0`; and `src_used=0` with a matching address → no hit, no stall.
- Hold and flush: load in stage 0 with `hold=1` for 3 cycles → stall held for 4 cycles total and `stall_cnt=4`; `flush` then clears entry 0 → stall drops next cycle.
- Saturation: preload `stall_cnt` near 0xFFFF_FFFF via a forced long stall → value stays at 0xFFFF_FFFF. Without `HAZARD_FWD_EN`, an ALU dependency at DEPTH=3 → 3 stall cycles.
